// File: rtl/mdu_controller.sv
// mdu_controller: HI/LO multiply/divide sequencer for the EXE stage.
// Owns the architectural HI/LO registers, a 1-bit/cycle restoring divider
// and a latency-modelled multiplier. It holds the issuing instruction in EXE
// (stall) until HI/LO are committed, and a flush cancels any in-flight op.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   op_valid, op      MDU instruction in EXE (000 MULT, 001 MULTU, 010 DIV,
//                     011 DIVU, 100 MTHI, 101 MTLO, 11x none)
//   src_a, src_b      forwarded rs / rt values
//   flush             cancel in-flight op, suppress any HI/LO write
//   stall             hold IF/ID/EXE this cycle
//   busy              sequencer is not idle
//   hi, lo            architectural HI / LO
module mdu_controller #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  localparam int CMAX = (MUL_LAT > DIV_STEPS) ? MUL_LAT : DIV_STEPS;
  localparam int CW   = $clog2(CMAX + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    opa_q, opb_q;   // multiplier operands; opb_q is the divisor magnitude for divides
  logic [31:0]    rem_q, quo_q;   // quo_q starts as the dividend and shifts into the quotient
  logic           mul_signed_q;
  logic           qneg_q, rneg_q; // post-divide sign corrections

  logic accept, mt_hi, mt_lo, op_is_div, op_sdiv;
  logic [31:0] a_mag, b_mag;

  assign op_is_div = op[1];
  assign op_sdiv   = (op == 3'b010);
  assign accept    = (state_q == S_IDLE) && op_valid && !op[2] && !flush;
  assign mt_hi     = (state_q == S_IDLE) && op_valid && (op == 3'b100) && !flush;
  assign mt_lo     = (state_q == S_IDLE) && op_valid && (op == 3'b101) && !flush;

  // Signed divide runs on magnitudes; -0x80000000 wraps to itself, which is
  // the correct unsigned magnitude.
  assign a_mag = (op_sdiv && src_a[31]) ? -src_a : src_a;
  assign b_mag = (op_sdiv && src_b[31]) ? -src_b : src_b;

  // Restoring step: shift the next dividend bit into the partial remainder and
  // subtract when it fits. A zero divisor naturally yields q=all-ones, r=|a|,
  // which after sign correction gives the defined divide-by-zero results.
  logic [32:0] rem_sh, rem_nx;
  logic        fits;
  assign rem_sh = {rem_q, quo_q[31]};
  assign fits   = (rem_sh >= {1'b0, opb_q});
  assign rem_nx = fits ? (rem_sh - {1'b0, opb_q}) : rem_sh;

  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{mul_signed_q & opa_q[31]}}, opa_q};
  assign mul_b = {{32{mul_signed_q & opb_q[31]}}, opb_q};
  assign prod  = mul_a * mul_b;

  logic [31:0] quo_fix, rem_fix;
  assign quo_fix = qneg_q ? -quo_q : quo_q;
  assign rem_fix = rneg_q ? -rem_q : rem_q;

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        stall   = 1'b1;
        state_d = op_is_div ? S_DIV : S_MUL;
      end
      S_MUL: begin
        stall = 1'b1;
        if (cnt_q == CW'(MUL_LAT - 1)) state_d = S_DONE;
      end
      S_DIV: begin
        stall = 1'b1;
        if (cnt_q == CW'(DIV_STEPS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        stall   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;  // op_valid still belongs to the finished instruction
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      stall   = 1'b0;
      state_d = S_IDLE;
    end
    // stall must read 0 while reset is held, even if EXE presents an MDU op.
    if (!rst) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      mul_signed_q <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      if (accept) begin
        cnt_q        <= '0;
        opa_q        <= src_a;
        opb_q        <= op_is_div ? b_mag : src_b;
        quo_q        <= a_mag;
        rem_q        <= '0;
        mul_signed_q <= !op[0];
        qneg_q       <= op_sdiv && (src_a[31] ^ src_b[31]);
        rneg_q       <= op_sdiv && src_a[31];
      end
      if (mt_hi) hi <= src_a;
      if (mt_lo) lo <= src_a;
      if (!flush) begin
        case (state_q)
          S_MUL: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(MUL_LAT - 1)) {hi, lo} <= prod;
          end
          S_DIV: begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_nx[31:0];
            quo_q <= {quo_q[30:0], fits};
          end
          S_FIX: begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller: directed plus randomized bench for mdu_controller.
// Expected HI/LO come from a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_mdu_controller;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0;
  logic        stall, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mdu_controller #(.MUL_LAT(MUL_LAT), .DIV_STEPS(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} for an arithmetic op.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int qi, ri;
    logic [31:0] h, l;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = a;
    ub = b;
    h = '0; l = '0;
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) begin
          h = a; l = a[31] ? 32'h1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 0; l = 32'h8000_0000;
        end else begin
          qi = int'(a) / int'(b);
          ri = int'(a) % int'(b);
          h = ri; l = qi;
        end
      end
      default: begin
        if (b == 0) begin
          h = a; l = 32'hFFFF_FFFF;
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
    return {h, l};
  endfunction

  // Issue an op with op_valid held while stalled, then check stall length,
  // result on the DONE cycle and return to idle without restart.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    logic [63:0] exp;
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    exp = model(o, a, b);
    check({tag, "_stall_cycles"}, 64'(n), o[1] ? 64'd34 : 64'(1 + MUL_LAT));
    check({tag, "_hi"}, {32'h0, hi}, {32'h0, exp[63:32]});
    check({tag, "_lo"}, {32'h0, lo}, {32'h0, exp[31:0]});
    check({tag, "_done_busy"}, {63'h0, busy}, 64'd1);
    @(negedge clk);
    op_valid = 1'b0; op = 3'b111;
    #1;
    check({tag, "_idle_busy"}, {63'h0, busy}, 64'd0);
  endtask

  task automatic set_hilo(input logic [31:0] v);
    @(negedge clk); op_valid = 1'b1; op = 3'b100; src_a = v;
    @(negedge clk); op = 3'b101;
    @(negedge clk); op_valid = 1'b0; op = 3'b111;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int sel;

    // Reset state
    #12;
    check("reset_hi", {32'h0, hi}, 64'h0);
    check("reset_lo", {32'h0, lo}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_stall", {63'h0, stall}, 64'h0);
    @(negedge clk); rst = 1'b1;

    // Directed divides and multiplies
    run_op(3'd3, 32'd7, 32'd2, "divu_7_2");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, "div_by0_neg");
    run_op(3'd3, 32'h1234_5678, 32'd0, "divu_by0");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1");
    run_op(3'd0, 32'h8000_0000, 32'd2, "mult_min2");

    // MTHI then MTLO on consecutive cycles
    @(negedge clk); op_valid = 1'b1; op = 3'b100; src_a = 32'h1234_5678; #1;
    check("mthi_stall", {63'h0, stall}, 64'h0);
    @(negedge clk); op = 3'b101; src_a = 32'hCAFE_F00D; #1;
    check("mtlo_stall", {63'h0, stall}, 64'h0);
    check("mthi_hi", {32'h0, hi}, 64'h1234_5678);
    @(negedge clk); op_valid = 1'b0; op = 3'b111; #1;
    check("mtlo_lo", {32'h0, lo}, 64'hCAFE_F00D);
    check("mthi_hold", {32'h0, hi}, 64'h1234_5678);

    // Flush on the 10th DIV cycle
    set_hilo(32'h55);
    @(negedge clk); op_valid = 1'b1; op = 3'b010; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(negedge clk);
    flush = 1'b1; #1;
    check("flush_div_stall", {63'h0, stall}, 64'h0);
    check("flush_div_busy_pre", {63'h0, busy}, 64'h1);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; op = 3'b111; #1;
    check("flush_div_busy", {63'h0, busy}, 64'h0);
    check("flush_div_hi", {32'h0, hi}, 64'h55);
    check("flush_div_lo", {32'h0, lo}, 64'h55);

    // Flush on the FIX cycle
    @(negedge clk); op_valid = 1'b1; op = 3'b010; src_a = 32'd100; src_b = 32'd7;
    repeat (33) @(negedge clk);
    #1;
    check("fix_stall_pre", {63'h0, stall}, 64'h1);
    flush = 1'b1; #1;
    check("flush_fix_stall", {63'h0, stall}, 64'h0);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; op = 3'b111; #1;
    check("flush_fix_busy", {63'h0, busy}, 64'h0);
    check("flush_fix_hi", {32'h0, hi}, 64'h55);
    check("flush_fix_lo", {32'h0, lo}, 64'h55);

    // Flush on the final MUL cycle
    @(negedge clk); op_valid = 1'b1; op = 3'b001; src_a = 32'd3; src_b = 32'd5;
    repeat (MUL_LAT) @(negedge clk);
    flush = 1'b1; #1;
    check("flush_mul_stall", {63'h0, stall}, 64'h0);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; op = 3'b111; #1;
    check("flush_mul_hi", {32'h0, hi}, 64'h55);
    check("flush_mul_lo", {32'h0, lo}, 64'h55);

    // Flush together with an accept: nothing starts
    @(negedge clk); op_valid = 1'b1; op = 3'b011; src_a = 32'd9; src_b = 32'd2; flush = 1'b1; #1;
    check("flush_accept_stall", {63'h0, stall}, 64'h0);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; op = 3'b111; #1;
    check("flush_accept_busy", {63'h0, busy}, 64'h0);

    // Reset asserted mid-MUL
    @(negedge clk); op_valid = 1'b1; op = 3'b001; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    check("mid_mul_busy", {63'h0, busy}, 64'h1);
    rst = 1'b0; #1;
    check("rst_mul_hi", {32'h0, hi}, 64'h0);
    check("rst_mul_lo", {32'h0, lo}, 64'h0);
    check("rst_mul_busy", {63'h0, busy}, 64'h0);
    check("rst_mul_stall", {63'h0, stall}, 64'h0);
    @(negedge clk); op_valid = 1'b0; op = 3'b111; rst = 1'b1;
    run_op(3'd3, 32'd100, 32'd7, "divu_100_7");

    // Randomized arithmetic ops against the model
    for (int i = 0; i < 10; i++) begin
      ro  = 3'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      rb = 32'd0;
      else if (sel == 1) rb = $urandom_range(1, 15);
      else if (sel == 2) rb = 32'hFFFF_FFFF;
      else               rb = $urandom;
      if (sel == 3) ra = {1'b1, 31'($urandom_range(0, 1000))};
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
